// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Mux-select encodings match the datapath muxes that consume them.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        LUI,
        ALU_WB,
        BRANCH,
        JAL,
        JALR,
        FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALUOUT  = 1'b1;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // States that hold a memory request open until mem_ready_i.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags when the limit is reached.
// A limit of 0 disables expiry entirely.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the shared RV32I datapath: per-state mux selects,
// write enables, memory handshake waits, and a sticky fault on bad opcode/timeout.
//
//   state     | meaning
//   FETCH     | read instruction at PC, PC <= PC+4 on ready
//   DECODE    | ALUOut <= oldPC+imm, dispatch on opcode
//   MEM_ADR   | ALUOut <= rs1+imm (load/store address)
//   MEM_READ  | data read at ALUOut, wait for ready
//   MEM_WB    | rd <= mem data
//   MEM_WRITE | data write at ALUOut, wait for ready
//   EXEC_R    | ALU on rs1,rs2 (funct decoded)
//   EXEC_I    | ALU on rs1,imm (funct decoded)
//   LUI       | ALUOut <= 0+imm
//   ALU_WB    | rd <= ALUOut
//   BRANCH    | compare rs1,rs2; PC <= target if taken
//   JALR      | ALUOut <= rs1+imm, then reuse JAL
//   JAL       | PC <= ALUOut, ALUOut <= oldPC+4
//   FAULT     | parked until reset
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode_i,
    input  logic       branch_cond_i,
    input  logic       mem_ready_i,
    output logic       mem_rd_en_o,
    output logic       mem_wr_en_o,
    output logic       adr_src_o,
    output logic       ir_wr_en_o,
    output logic       pc_wr_en_o,
    output logic       reg_wr_en_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic       branch_o,
    output logic       instr_retired_o,
    output logic       fault_o
);

    state_t state;
    state_t state_next;
    logic   timer_inc;
    logic   timer_clear;
    logic   timeout;

    // Counter only runs while a wait state is stalled; any progress or exit clears it.
    assign timer_inc   = is_wait_state(state) && !mem_ready_i;
    assign timer_clear = !timer_inc || timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expired(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        mem_rd_en_o     = 1'b0;
        mem_wr_en_o     = 1'b0;
        adr_src_o       = ADR_PC;
        ir_wr_en_o      = 1'b0;
        pc_wr_en_o      = 1'b0;
        reg_wr_en_o     = 1'b0;
        alu_src_a_o     = SRCA_PC;
        alu_src_b_o     = SRCB_RS2;
        alu_op_o        = ALUOP_ADD;
        result_src_o    = RES_ALUOUT;
        branch_o        = 1'b0;
        instr_retired_o = 1'b0;
        fault_o         = 1'b0;

        case (state)
            FETCH: begin
                mem_rd_en_o  = 1'b1;
                adr_src_o    = ADR_PC;
                alu_src_a_o  = SRCA_PC;
                alu_src_b_o  = SRCB_FOUR;
                alu_op_o     = ALUOP_ADD;
                result_src_o = RES_ALU;
                if (mem_ready_i) begin
                    ir_wr_en_o = 1'b1;
                    pc_wr_en_o = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_next = MEM_ADR;
                    OP_R:              state_next = EXEC_R;
                    OP_IMM:            state_next = EXEC_I;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = ALU_WB;
                    default:           state_next = FAULT;
                endcase
            end
            MEM_ADR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                state_next  = (opcode_i == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                adr_src_o   = ADR_ALUOUT;
                mem_rd_en_o = 1'b1;
                if (mem_ready_i) begin
                    state_next = MEM_WB;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            MEM_WB: begin
                result_src_o    = RES_MEMDATA;
                reg_wr_en_o     = 1'b1;
                instr_retired_o = 1'b1;
                state_next      = FETCH;
            end
            MEM_WRITE: begin
                adr_src_o   = ADR_ALUOUT;
                mem_wr_en_o = 1'b1;
                if (mem_ready_i) begin
                    instr_retired_o = 1'b1;
                    state_next      = FETCH;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            EXEC_R: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_RS2;
                alu_op_o    = ALUOP_FUNCT;
                state_next  = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_FUNCT;
                state_next  = ALU_WB;
            end
            LUI: begin
                alu_src_a_o = SRCA_ZERO;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                state_next  = ALU_WB;
            end
            ALU_WB: begin
                result_src_o    = RES_ALUOUT;
                reg_wr_en_o     = 1'b1;
                instr_retired_o = 1'b1;
                state_next      = FETCH;
            end
            BRANCH: begin
                alu_src_a_o     = SRCA_RS1;
                alu_src_b_o     = SRCB_RS2;
                alu_op_o        = ALUOP_BRANCH;
                result_src_o    = RES_ALUOUT;
                branch_o        = 1'b1;
                pc_wr_en_o      = branch_cond_i;
                instr_retired_o = 1'b1;
                state_next      = FETCH;
            end
            JALR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                state_next  = JAL;
            end
            JAL: begin
                alu_src_a_o  = SRCA_OLDPC;
                alu_src_b_o  = SRCB_FOUR;
                alu_op_o     = ALUOP_ADD;
                result_src_o = RES_ALUOUT;
                pc_wr_en_o   = 1'b1;
                state_next   = ALU_WB;
            end
            FAULT: begin
                fault_o    = 1'b1;
                state_next = FAULT;
            end
            default: begin
                state_next = FAULT;
            end
        endcase

        // Reset abandons the instruction with every output quiet in that cycle.
        if (rst) begin
            mem_rd_en_o     = 1'b0;
            mem_wr_en_o     = 1'b0;
            adr_src_o       = 1'b0;
            ir_wr_en_o      = 1'b0;
            pc_wr_en_o      = 1'b0;
            reg_wr_en_o     = 1'b0;
            alu_src_a_o     = 2'b00;
            alu_src_b_o     = 2'b00;
            alu_op_o        = 2'b00;
            result_src_o    = 2'b00;
            branch_o        = 1'b0;
            instr_retired_o = 1'b0;
            fault_o         = 1'b0;
        end
    end

endmodule
